// File: rtl/seg_value_writer.sv
// seg_value_writer
//   Converts a 14-bit binary value to four BCD digits (sequential
//   double-dabble, one iteration per clock), encodes each digit as an
//   active-low 7-segment byte and writes the four bytes to the LED scan
//   driver registers at BASE_ADDR (ones) .. BASE_ADDR+3 (thousands) over a
//   bus shared with the CPU via a req/gnt handshake.
//
// Ports
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   start    in   request a conversion (sampled only when idle)
//   value    in   14-bit binary value, 0..9999 displayable; larger shows dashes
//   dp       in   decimal point per digit, bit0 = ones
//   busy     out  operation in progress (cycle after start through done)
//   done     out  one-cycle pulse after the last write
//   bus_req  out  bus request, high while writing
//   bus_gnt  in   bus granted this cycle
//   we       out  write strobe, bus_req & bus_gnt
//   addr     out  write address
//   out      out  segment byte, active-low, bit7 = decimal point

module seg_value_writer #(
    parameter logic [7:0] BASE_ADDR = 8'd214,
    parameter bit         BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] value,
    input  logic [3:0]  dp,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        we,
    output logic [7:0]  addr,
    output logic [7:0]  out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [13:0] r_val;
    logic [3:0]  r_dp;
    logic        r_ovf;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [1:0]  r_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_req;
    logic [7:0]  r_addr;
    logic [7:0]  r_out;

    logic [15:0] w_bcd_adj;
    logic [15:0] w_bcd_next;

    // One double-dabble step: +3 on every nibble >= 5, then shift in the next
    // value bit (MSB first).
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned n = 0; n < 4; n++) begin
            if (r_bcd[4*n +: 4] >= 4'd5) begin
                w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[14:0], r_val[13]};
    end

    // Segment byte for digit idx. Overflow forces a dash and suppresses
    // blanking; the decimal point is applied last so it shows on blanks too.
    function automatic logic [7:0] f_encode(
        input logic [15:0] bcd,
        input logic [1:0]  idx,
        input logic [3:0]  dpm,
        input logic        ovf
    );
        logic [3:0] dig;
        logic [7:0] seg;
        logic       lz;
        dig = bcd[4*idx +: 4];
        // Leading zero: this digit and every higher one are zero.
        lz  = (idx != 2'd0) && ((bcd >> {idx, 2'b00}) == 16'd0);
        case (dig)
            4'd0:    seg = 8'b11000000;
            4'd1:    seg = 8'b11111001;
            4'd2:    seg = 8'b10100100;
            4'd3:    seg = 8'b10110000;
            4'd4:    seg = 8'b10011001;
            4'd5:    seg = 8'b10010010;
            4'd6:    seg = 8'b10000010;
            4'd7:    seg = 8'b11011000;
            4'd8:    seg = 8'b10000000;
            4'd9:    seg = 8'b10010000;
            default: seg = 8'b11111111;
        endcase
        if (ovf) begin
            seg = 8'b10111111;
        end else if (BLANK_LZ && lz) begin
            seg = 8'b11111111;
        end
        if (dpm[idx]) begin
            seg[7] = 1'b0;
        end
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_val   <= '0;
            r_dp    <= '0;
            r_ovf   <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_out   <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_val   <= value;
                        r_dp    <= dp;
                        r_ovf   <= (value > 14'd9999);
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_val <= {r_val[12:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        // Present the ones digit from the final BCD result so
                        // the first write can go out in the very next cycle.
                        r_state <= S_WRITE;
                        r_idx   <= 2'd0;
                        r_req   <= 1'b1;
                        r_addr  <= BASE_ADDR;
                        r_out   <= f_encode(w_bcd_next, 2'd0, r_dp, r_ovf);
                    end
                end
                S_WRITE: begin
                    if (bus_gnt) begin
                        if (r_idx == 2'd3) begin
                            r_state <= S_DONE;
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                            r_out   <= '1;
                        end else begin
                            r_idx  <= r_idx + 2'd1;
                            r_addr <= BASE_ADDR + {6'd0, r_idx + 2'd1};
                            r_out  <= f_encode(r_bcd, r_idx + 2'd1, r_dp, r_ovf);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bus_req = r_req;
    assign we      = r_req & bus_gnt;
    assign addr    = r_addr;
    assign out     = r_out;

endmodule

// File: tb/tb_seg_value_writer.sv
// tb_seg_value_writer
//   Self-checking bench for seg_value_writer. Expected writes and done pulses
//   (with the cycle they must appear in) are queued when an operation is
//   started and compared as the DUT produces them. A second instance with
//   leading-zero blanking disabled covers the show-all-digits variant.

module tb_seg_value_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_nb;
    logic        bus_gnt;
    logic        gnt_nb;
    logic [13:0] value;
    logic [3:0]  dp;

    logic        busy, done, bus_req, we;
    logic [7:0]  addr, out;
    logic        busy_nb, done_nb, bus_req_nb, we_nb;
    logic [7:0]  addr_nb, out_nb;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t wq[$];
    int  dq[$];

    seg_value_writer #(.BASE_ADDR(8'd214), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .dp(dp),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .we(we), .addr(addr), .out(out)
    );

    seg_value_writer #(.BASE_ADDR(8'd214), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start_nb), .value(value), .dp(dp),
        .busy(busy_nb), .done(done_nb), .bus_req(bus_req_nb), .bus_gnt(gnt_nb),
        .we(we_nb), .addr(addr_nb), .out(out_nb)
    );

    always #5 clk = ~clk;

    // Cycle label: value of cyc after the posedge that opens the cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference encoding computed arithmetically from the binary value.
    function automatic logic [7:0] exp_byte(input int v, input logic [3:0] d, input int i, input bit blz);
        logic [7:0] b;
        int p;
        p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        if (v > 9999) begin
            b = 8'b10111111;
        end else if (blz && i > 0 && (v / p) == 0) begin
            b = 8'b11111111;
        end else begin
            case ((v / p) % 10)
                0: b = 8'b11000000;
                1: b = 8'b11111001;
                2: b = 8'b10100100;
                3: b = 8'b10110000;
                4: b = 8'b10011001;
                5: b = 8'b10010010;
                6: b = 8'b10000010;
                7: b = 8'b11011000;
                8: b = 8'b10000000;
                9: b = 8'b10010000;
                default: b = 8'b11111111;
            endcase
        end
        if (d[i]) b[7] = 1'b0;
        return b;
    endfunction

    // mode 0: grant always high; mode 1: 5-cycle stall before the first
    // write and 2-cycle stall between the 2nd and 3rd writes.
    task automatic push_op(input int v, input logic [3:0] d, input int L, input int mode);
        int c;
        for (int i = 0; i < 4; i++) begin
            c = L + 15 + i;
            if (mode == 1) c = c + ((i < 2) ? 5 : 7);
            wq.push_back('{a: 8'(214 + i), d: exp_byte(v, d, i, 1'b1), c: c});
        end
        dq.push_back(L + 19 + ((mode == 1) ? 7 : 0));
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (we) begin
            if (wq.size() == 0) begin
                check("unexp_we", 32'(we), 0);
            end else begin
                e = wq.pop_front();
                check("wr_addr", 32'(addr), 32'(e.a));
                check("wr_out", 32'(out), 32'(e.d));
                check("wr_cycle", cyc, e.c);
            end
        end else if (bus_req && wq.size() != 0) begin
            check("stall_addr", 32'(addr), 32'(wq[0].a));
            check("stall_out", 32'(out), 32'(wq[0].d));
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("unexp_done", 32'(done), 0);
            end else begin
                check("done_cycle", cyc, dq.pop_front());
                check("done_busy", 32'(busy), 1);
            end
        end
    end

    task automatic do_op(input int v, input logic [3:0] d, input int mode, input bit extra);
        int L;
        int dk;
        @(posedge clk); #1;
        L = cyc;
        value = 14'(v); dp = d; start = 1'b1; bus_gnt = 1'b1;
        push_op(v, d, L, mode);
        check("idle_busy", 32'(busy), 0);
        dk = 19 + ((mode == 1) ? 7 : 0);
        for (int k = 1; k <= dk + 1; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            value = 14'($urandom);
            dp    = 4'($urandom);
            if (extra && k == 5) begin
                start = 1'b1;
                value = 14'((v + 1111) % 10000);
            end
            bus_gnt = !(mode == 1 && ((k >= 15 && k <= 19) || k == 22 || k == 23));
            check("busy", 32'(busy), 32'(k <= dk));
        end
        check("wq_drain", wq.size(), 0);
        check("dq_drain", dq.size(), 0);
    endtask

    task automatic do_b2b(input int v0, input int v1, input int v2);
        int L;
        @(posedge clk); #1;
        L = cyc;
        value = 14'(v0); dp = 4'b0000; start = 1'b1; bus_gnt = 1'b1;
        push_op(v0, 4'b0000, L, 0);
        push_op(v1, 4'b0000, L + 20, 0);
        push_op(v2, 4'b0000, L + 40, 0);
        for (int k = 1; k <= 61; k++) begin
            @(posedge clk); #1;
            start = (k <= 40);
            if (k == 20)      value = 14'(v1);
            else if (k == 40) value = 14'(v2);
            else              value = 14'($urandom);
            check("b2b_busy", 32'(busy), 32'(k < 60 && (k % 20) != 0));
        end
        start = 1'b0;
        check("b2b_wq_drain", wq.size(), 0);
        check("b2b_dq_drain", dq.size(), 0);
    endtask

    task automatic do_reset_mid(input int v, input int k_rst, input int n_written);
        int L;
        @(posedge clk); #1;
        L = cyc;
        value = 14'(v); dp = 4'b0000; start = 1'b1; bus_gnt = 1'b1;
        push_op(v, 4'b0000, L, 0);
        for (int k = 1; k <= k_rst + 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            value = 14'($urandom);
            rst_n = (k != k_rst);
            if (k == k_rst + 1) begin
                check("rst_wr_left", wq.size(), 4 - n_written);
                wq.delete();
                dq.delete();
                check("rst_busy", 32'(busy), 0);
                check("rst_bus_req", 32'(bus_req), 0);
                check("rst_done", 32'(done), 0);
                check("rst_addr", 32'(addr), 0);
                check("rst_out", 32'(out), 32'hFF);
            end else if (k > k_rst + 1) begin
                check("post_rst_busy", 32'(busy), 0);
            end
        end
    endtask

    task automatic do_nb(input int v);
        @(posedge clk); #1;
        value = 14'(v); dp = 4'b0000; start_nb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start_nb = 1'b0;
            if (k >= 15 && k <= 18) begin
                check("nb_we", 32'(we_nb), 1);
                check("nb_addr", 32'(addr_nb), 32'(214 + k - 15));
                check("nb_out", 32'(out_nb), 32'(exp_byte(v, 4'b0000, k - 15, 1'b0)));
            end else begin
                check("nb_we_idle", 32'(we_nb), 0);
            end
            check("nb_req", 32'(bus_req_nb), 32'(k >= 15 && k <= 18));
            check("nb_done", 32'(done_nb), 32'(k == 19));
            check("nb_busy", 32'(busy_nb), 32'(k <= 19));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_nb = 1'b0;
        bus_gnt = 1'b1; gnt_nb = 1'b1;
        value = '0; dp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_req", 32'(bus_req), 0);
        check("reset_we", 32'(we), 0);
        check("reset_addr", 32'(addr), 0);
        check("reset_out", 32'(out), 32'hFF);
        rst_n = 1'b1;

        do_op(1234, 4'b0000, 0, 1'b0);
        do_op(7, 4'b0000, 0, 1'b0);
        do_op(0, 4'b0000, 0, 1'b0);
        do_nb(0);
        do_op(10000, 4'b0000, 0, 1'b0);
        do_op(16383, 4'b0000, 0, 1'b0);
        do_op(9999, 4'b0000, 0, 1'b0);
        do_op(9999, 4'b0010, 0, 1'b0);
        do_op(10500, 4'b1010, 0, 1'b0);
        do_op(5070, 4'b1001, 1, 1'b0);
        do_op(4321, 4'b0000, 0, 1'b1);
        do_b2b(42, 8005, 300);
        do_reset_mid(2468, 5, 0);
        do_reset_mid(1357, 16, 2);
        do_op(905, 4'b0100, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_op(int'($urandom_range(0, 16383)), 4'($urandom), 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_value_writer.md
Name: seg_value_writer

Overview:
- Bus-master stage directly upstream of the four-digit LED scan driver.
- Takes a 14-bit binary value and converts it to BCD with a sequential double-dabble.
- Encodes each digit to an active-low 7-segment byte, then issues four write cycles to the display registers at BASE_ADDR..BASE_ADDR+3.
- Shares the data bus with the CPU through a req/gnt handshake.

Parameters:
- BASE_ADDR, 8'd214: address of the ones-digit register. Tens, hundreds and thousands are at +1, +2, +3.
- BLANK_LZ, 1: 1 blanks leading zeros (the ones digit is never blanked); 0 shows all digits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- value  input  14  binary value; valid range 0..9999.
- dp  input  4  decimal-point enable per digit; bit0 = ones.
- busy  output  1  high from the cycle after start is accepted through DONE.
- done  output  1  one-cycle pulse after the last write.
- bus_req  output  1  high throughout WRITE.
- bus_gnt  input  1  bus granted this cycle.
- we  output  1  write strobe (= bus_req & bus_gnt).
- addr  output  8  write address.
- out  output  8  segment byte, active-low, bit7 = dp.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - busy, done, bus_req, we = 0; addr=0; out=8'hFF.
  - Latched value, dp, BCD shift register and counters cleared.
  - Applies mid-operation too: remaining writes are abandoned, no partial write follows, done is not pulsed.
- IDLE: start=1 → latch value and dp, clear BCD, cnt=0 → CONV. start while busy is ignored (not queued).
- CONV:
  - 14 cycles, one double-dabble iteration per cycle: add 3 to every BCD nibble ≥5, then shift left, taking the latched value MSB first.
  - After iteration 14 → WRITE, idx=0.
  - Overflow: if latched value >9999, conversion still takes 14 cycles; every digit is forced to dash (8'b10111111) and blanking is suppressed.
- Encoding, active-low with bit7=dp:
  - 0 = 11000000
  - 1 = 11111001
  - 2 = 10100100
  - 3 = 10110000
  - 4 = 10011001
  - 5 = 10010010
  - 6 = 10000010
  - 7 = 11011000
  - 8 = 10000000
  - 9 = 10010000
  - blank = 11111111
  - If dp[idx]=1, bit7 is cleared after encoding; this applies to blanked digits and dashes as well.
- Leading-zero blanking: with BLANK_LZ=1, digit k (k≥1) is blanked when it and all higher digits are 0.
- WRITE:
  - bus_req=1; addr=BASE_ADDR+idx; out=encoded digit idx. addr and out are stable while stalled.
  - On a cycle with bus_gnt=1: we=1 and idx increments. After the idx=3 write → DONE.
  - bus_gnt=0 stalls indefinitely with we=0 and no timeout.
- DONE: done=1 for exactly one cycle, busy still 1 → IDLE. busy drops and a new start is accepted in the following IDLE cycle.
- Latency with bus_gnt tied 1 and start sampled at cycle 0:
  - CONV cycles 1–14.
  - Writes in cycles 15 (ones), 16, 17, 18 (thousands).
  - done in cycle 19.
  - busy high cycles 1–19.
  - Earliest next accepted start: cycle 20.
- Input changes: value/dp changes after start acceptance have no effect on the current operation.

Test Plan:
- value=1234, dp=0, gnt=1 → writes (214,10011001), (215,10110000), (216,10100100), (217,11111001) in cycles 15–18; done in cycle 19 only.
- value=7 then value=0, BLANK_LZ=1:
  - 7 → 214:11011000; 215–217:11111111.
  - 0 → 214:11000000; others 11111111.
  - Repeat 0 with BLANK_LZ=0 → all four 11000000.
- value=10000 and value=16383 → all four writes 10111111. value=9999 → all 10010000. dp=4'b0010 with 9999 → 215 write is 00010000.
- bus_gnt low for 5 cycles at the start of WRITE and for 2 cycles between the 2nd and 3rd writes → bus_req held; addr/out frozen; we only when gnt=1; done 7 cycles later than the gnt=1 timing.
- start pulsed during CONV with a different value → ignored; only the original value is written. start held high continuously → back-to-back operations every 20 cycles.
- rst_n=0 for one cycle during CONV, and again after the second write → no further we, done never pulses. Outputs at reset values: busy=0, bus_req=0, out=FF. The next start completes normally.
